// File: rtl/cacheline_adapter_burst_if.sv
// Signal bundle between the L2 line port and the 64-bit burst memory port.
// The adapter takes the slave view; the cache/memory side takes the master view.
interface cacheline_adapter_burst_if #(
  parameter int unsigned s_line = 256,
  parameter int unsigned s_beat = 64
);
  logic [s_line-1:0] line_i;
  logic [s_line-1:0] line_o;
  logic [31:0]       address_i;
  logic [31:0]       address_o;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [s_beat-1:0] burst_i;
  logic [s_beat-1:0] burst_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adapter_burst.sv
// Converts 256-bit cache line fills/write-backs into 4-beat 64-bit memory bursts.
// Define CACHELINE_ADAPTER_WRAP_EN for critical-word-first wrap bursts.
module cacheline_adapter_burst #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_beat   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  cacheline_adapter_burst_if.slave bus
);
  localparam int unsigned beat_off = $clog2(s_beat / 8);
  localparam int unsigned cnt_w    = s_offset - beat_off;
  localparam int unsigned beat_sh  = $clog2(s_beat);
  localparam int unsigned idx_w    = cnt_w + beat_sh;
`ifdef CACHELINE_ADAPTER_WRAP_EN
  localparam logic [31:0] addr_mask = ~32'((1 << beat_off) - 1);
`else
  localparam logic [31:0] addr_mask = ~32'((1 << s_offset) - 1);
`endif

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e            state_q, state_d;
  logic [cnt_w-1:0]  beat_cnt_q, beat_cnt_d;
  logic [cnt_w-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [s_line-1:0] buf_q, buf_d;
  logic [s_line-1:0] line_q, line_d;
  logic [s_beat-1:0] burst_q, burst_d;
  logic [31:0]       addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              resp_q, resp_d;
  logic [cnt_w-1:0]  start_beat;
  logic [idx_w-1:0]  rd_idx;
  logic [idx_w-1:0]  wr_idx;

`ifdef CACHELINE_ADAPTER_WRAP_EN
  assign start_beat = bus.address_i[beat_off +: cnt_w];
`else
  assign start_beat = '0;
`endif

  assign rd_idx = {beat_cnt_q, beat_sh'(0)};

  // Next-state and output-register computation.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    buf_d      = buf_q;
    line_d     = line_q;
    burst_d    = burst_q;
    addr_d     = addr_q;

    case (state_q)
      IDLE: begin
        if (bus.write_i || bus.read_i) begin
          state_d    = bus.write_i ? WRITE : READ;
          addr_d     = bus.address_i & addr_mask;
          beat_cnt_d = start_beat;
          xfer_cnt_d = '0;
          if (bus.write_i) buf_d = bus.line_i;
        end
      end
      WRITE, READ: begin
        if (bus.resp_i) begin
          if (state_q == READ) line_d[rd_idx +: s_beat] = bus.burst_i;
          beat_cnt_d = beat_cnt_q + cnt_w'(1);
          xfer_cnt_d = xfer_cnt_q + cnt_w'(1);
          if (xfer_cnt_q == '1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // burst_o must already show the beat selected for the coming cycle
    wr_idx = {beat_cnt_d, beat_sh'(0)};
    if (state_d == WRITE) burst_d = buf_d[wr_idx +: s_beat];

    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      xfer_cnt_q <= '0;
      buf_q      <= '0;
      line_q     <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      buf_q      <= buf_d;
      line_q     <= line_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      resp_q     <= resp_d;
    end
  end

  assign bus.line_o    = line_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
endmodule
